audio_flash_reader: RTL and testbench

- Consumer side of the keyboard playback-control interface: takes level signals direction, pause and restart and streams 16-bit audio samples out of word-addressed flash.
- Each 32-bit flash word holds two samples.
- Forward play emits the low half, then the high half; backward play emits the high half, then the low half.
- Paced by an external sample-rate strobe; sits between the keyboard control FSM, the flash controller read port and the audio DAC path.

---
 rtl/audio_reader_pkg.sv | 25 ++
 rtl/audio_addr_step.sv | 26 ++
 rtl/audio_flash_reader.sv | 146 ++++++++++++++
 tb/tb_audio_flash_reader.sv | 396 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_reader_pkg.sv
// Shared types and constants for the flash audio reader.
package audio_reader_pkg;

  // Playback controller states.
  typedef enum logic [1:0] {
    WAIT_TICK = 2'd0,
    REQ       = 2'd1,
    WAIT_DATA = 2'd2,
    HOLD      = 2'd3
  } state_t;

  // Direction encoding as seen on the direction input.
  localparam logic FWD = 1'b1;
  localparam logic BWD = 1'b0;

  // Width of one audio sample; a flash word carries two of them.
  localparam int SAMPLE_W = 16;

  // Select the upper or lower sample of a 32-bit flash word.
  function automatic logic [SAMPLE_W-1:0] pick_half(input logic [2*SAMPLE_W-1:0] word,
                                                     input logic upper);
    return upper ? word[2*SAMPLE_W-1:SAMPLE_W] : word[SAMPLE_W-1:0];
  endfunction

endpackage

// File: rtl/audio_addr_step.sv
// Combinational word-address stepper with wrap between the clip bounds.
module audio_addr_step
  import audio_reader_pkg::*;
#(
  parameter int              ADDR_W     = 23,
  parameter logic [ADDR_W-1:0] START_ADDR = 23'h000000,
  parameter logic [ADDR_W-1:0] END_ADDR   = 23'h07FFFF
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic              direction,
  output logic [ADDR_W-1:0] next_addr
);

  // Forward wraps END->START, backward wraps START->END.
  always_comb begin
    next_addr = addr;
    if (direction == FWD) begin
      if (addr == END_ADDR) next_addr = START_ADDR;
      else                  next_addr = addr + 1'b1;
    end else begin
      if (addr == START_ADDR) next_addr = END_ADDR;
      else                    next_addr = addr - 1'b1;
    end
  end

endmodule

// File: rtl/audio_flash_reader.sv
// Streams 16-bit samples from word-addressed flash, two samples per word,
// paced by an external sample-rate strobe and steered by the keyboard
// controls (direction, pause, restart).
module audio_flash_reader
  import audio_reader_pkg::*;
#(
  parameter int              ADDR_W     = 23,
  parameter logic [ADDR_W-1:0] START_ADDR = 23'h000000,
  parameter logic [ADDR_W-1:0] END_ADDR   = 23'h07FFFF
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                sample_tick,
  input  logic                direction,
  input  logic                pause,
  input  logic                restart,
  output logic [ADDR_W-1:0]   mem_address,
  output logic                mem_read,
  input  logic                mem_waitrequest,
  input  logic [31:0]         mem_readdata,
  input  logic                mem_readdatavalid,
  output logic [SAMPLE_W-1:0] audio_sample,
  output logic                audio_valid,
  output logic                tick_missed
);

  state_t              state_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic [ADDR_W-1:0]   mem_address_reg;
  logic                mem_read_reg;
  logic [31:0]         word_reg;
  logic [SAMPLE_W-1:0] audio_sample_reg;
  logic                audio_valid_reg;
  logic                tick_missed_reg;
  logic                restart_pending_reg;

  logic [ADDR_W-1:0]   step_addr;
  logic [ADDR_W-1:0]   restart_addr;
  logic                tick_go;

  // A tick only counts when playback is not paused.
  assign tick_go = sample_tick & ~pause;

  // Clip start depends on the direction of play.
  assign restart_addr = (direction == FWD) ? START_ADDR : END_ADDR;

  audio_addr_step #(
    .ADDR_W    (ADDR_W),
    .START_ADDR(START_ADDR),
    .END_ADDR  (END_ADDR)
  ) u_addr_step (
    .addr     (addr_reg),
    .direction(direction),
    .next_addr(step_addr)
  );

  // Playback FSM with registered memory and audio outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg           <= WAIT_TICK;
      addr_reg            <= START_ADDR;
      mem_address_reg     <= START_ADDR;
      mem_read_reg        <= 1'b0;
      word_reg            <= '0;
      audio_sample_reg    <= '0;
      audio_valid_reg     <= 1'b0;
      tick_missed_reg     <= 1'b0;
      restart_pending_reg <= 1'b0;
    end else begin
      audio_valid_reg <= 1'b0;

      // Restart in any state clears the overrun flag.
      if (restart) tick_missed_reg <= 1'b0;

      case (state_reg)
        WAIT_TICK: begin
          // Restart wins over a coincident tick; that tick is simply dropped.
          if (restart) begin
            addr_reg <= restart_addr;
          end else if (tick_go) begin
            mem_read_reg    <= 1'b1;
            mem_address_reg <= addr_reg;
            state_reg       <= REQ;
          end
        end

        REQ: begin
          // The read is never aborted; a restart is remembered instead.
          if (restart) begin
            restart_pending_reg <= 1'b1;
          end else if (tick_go) begin
            tick_missed_reg <= 1'b1;
          end
          if (!mem_waitrequest) begin
            mem_read_reg <= 1'b0;
            state_reg    <= WAIT_DATA;
          end
        end

        WAIT_DATA: begin
          if (tick_go && !restart) tick_missed_reg <= 1'b1;
          if (mem_readdatavalid) begin
            word_reg <= mem_readdata;
            // A restart that arrives with the data is treated like a pending one.
            if (restart_pending_reg || restart) begin
              addr_reg            <= restart_addr;
              restart_pending_reg <= 1'b0;
              state_reg           <= WAIT_TICK;
            end else begin
              audio_sample_reg <= pick_half(mem_readdata, direction == BWD);
              audio_valid_reg  <= 1'b1;
              state_reg        <= HOLD;
            end
          end else if (restart) begin
            restart_pending_reg <= 1'b1;
          end
        end

        HOLD: begin
          // Second half of the word goes out on the next accepted tick.
          if (restart) begin
            addr_reg  <= restart_addr;
            state_reg <= WAIT_TICK;
          end else if (tick_go) begin
            audio_sample_reg <= pick_half(word_reg, direction == FWD);
            audio_valid_reg  <= 1'b1;
            addr_reg         <= step_addr;
            state_reg        <= WAIT_TICK;
          end
        end

        default: begin
          state_reg    <= WAIT_TICK;
          mem_read_reg <= 1'b0;
        end
      endcase
    end
  end

  assign mem_address  = mem_address_reg;
  assign mem_read     = mem_read_reg;
  assign audio_sample = audio_sample_reg;
  assign audio_valid  = audio_valid_reg;
  assign tick_missed  = tick_missed_reg;

endmodule

// File: tb/tb_audio_flash_reader.sv
// Directed self-checking bench for audio_flash_reader with a simple
// Avalon-style flash model (configurable stall and read latency).
module tb_audio_flash_reader;

  logic        clock;
  logic        reset;
  logic        sample_tick;
  logic        direction;
  logic        pause;
  logic        restart;
  logic [22:0] mem_address;
  logic        mem_read;
  logic        mem_waitrequest;
  logic [31:0] mem_readdata;
  logic        mem_readdatavalid;
  logic [15:0] audio_sample;
  logic        audio_valid;
  logic        tick_missed;

  int checks = 0;
  int passes = 0;

  // Memory model configuration (written only by the stimulus process)
  int stall_cfg  = 0;
  int rd_lat_cfg = 1;

  // Memory model state (written only by the memory process)
  int          acc_cnt;
  int          rdv_cnt;
  int          rdv_cyc;
  logic [22:0] acc_log[$];
  int          st_left;
  bit          in_req;
  int          rd_cnt;
  logic [22:0] rd_addr;

  // Output monitor state
  int          valid_cnt;
  int          av_cyc;
  logic [15:0] last_sample;

  int cyc = 0;

  audio_flash_reader dut (
    .clock            (clock),
    .reset            (reset),
    .sample_tick      (sample_tick),
    .direction        (direction),
    .pause            (pause),
    .restart          (restart),
    .mem_address      (mem_address),
    .mem_read         (mem_read),
    .mem_waitrequest  (mem_waitrequest),
    .mem_readdata     (mem_readdata),
    .mem_readdatavalid(mem_readdatavalid),
    .audio_sample     (audio_sample),
    .audio_valid      (audio_valid),
    .tick_missed      (tick_missed)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [31:0] mem_word(input logic [22:0] a);
    case (a)
      23'h000000: return 32'hBBBB_AAAA;
      23'h000001: return 32'hDDDD_CCCC;
      23'h07FFFF: return 32'h2222_1111;
      23'h07FFFE: return 32'h4444_3333;
      default:    return {9'h0, a} ^ 32'h5A5A_0000;
    endcase
  endfunction

  // Flash model: decides waitrequest / readdatavalid for the coming edge.
  always @(negedge clock) begin
    mem_readdatavalid = 1'b0;
    if (reset) begin
      mem_waitrequest = 1'b0;
      acc_cnt = 0;
      rdv_cnt = 0;
      rdv_cyc = 0;
      acc_log.delete();
      in_req  = 1'b0;
      st_left = 0;
      rd_cnt  = 0;
    end else begin
      if (rd_cnt > 0) begin
        rd_cnt = rd_cnt - 1;
        if (rd_cnt == 0) begin
          mem_readdatavalid = 1'b1;
          mem_readdata      = mem_word(rd_addr);
          rdv_cnt           = rdv_cnt + 1;
          rdv_cyc           = cyc;
        end
      end
      if (mem_read) begin
        if (!in_req) begin
          in_req  = 1'b1;
          st_left = stall_cfg;
        end
        if (st_left > 0) begin
          mem_waitrequest = 1'b1;
          st_left = st_left - 1;
        end else begin
          mem_waitrequest = 1'b0;
          in_req  = 1'b0;
          acc_log.push_back(mem_address);
          acc_cnt = acc_cnt + 1;
          rd_cnt  = rd_lat_cfg;
          rd_addr = mem_address;
        end
      end else begin
        mem_waitrequest = 1'b0;
      end
    end
  end

  // Audio output monitor.
  always @(negedge clock) begin
    if (reset) begin
      valid_cnt   = 0;
      av_cyc      = 0;
      last_sample = 16'h0;
    end else if (audio_valid) begin
      valid_cnt   = valid_cnt + 1;
      av_cyc      = cyc;
      last_sample = audio_sample;
      $display("[%0d] audio sample %h (count %0d)", cyc, audio_sample, valid_cnt);
    end
  end

  task automatic do_reset();
    reset       = 1'b1;
    sample_tick = 1'b0;
    pause       = 1'b0;
    restart     = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic tick();
    @(negedge clock);
    sample_tick = 1'b1;
    @(negedge clock);
    sample_tick = 1'b0;
  endtask

  task automatic restart_pulse();
    @(negedge clock);
    restart = 1'b1;
    @(negedge clock);
    restart = 1'b0;
  endtask

  task automatic wait_valid(input int target);
    for (int i = 0; i < 60; i++) begin
      if (valid_cnt >= target) return;
      @(negedge clock);
    end
    checks++;
    $display("FAIL wait_valid: timeout, count %0d required %0d", valid_cnt, target);
  endtask

  task automatic wait_acc(input int target);
    for (int i = 0; i < 60; i++) begin
      if (acc_cnt >= target) return;
      @(negedge clock);
    end
    checks++;
    $display("FAIL wait_acc: timeout, reads %0d required %0d", acc_cnt, target);
  endtask

  task automatic test_reset();
    do_reset();
    direction = 1'b1; stall_cfg = 0; rd_lat_cfg = 1;
    tick(); wait_valid(1);
    tick(); wait_valid(2);
    stall_cfg = 3;
    tick();
    // Mid-transaction async reset must drop mem_read at once.
    #2 reset = 1'b1;
    #1;
    checks++;
    if (mem_read !== 1'b0) $display("FAIL reset_async_read: got %b required 0", mem_read);
    else passes++;
    stall_cfg = 0;
    do_reset();
    checks++;
    if (mem_address !== 23'h0) $display("FAIL reset_addr: got %h required 000000", mem_address);
    else passes++;
    checks++;
    if (audio_sample !== 16'h0) $display("FAIL reset_sample: got %h required 0000", audio_sample);
    else passes++;
    checks++;
    if (audio_valid !== 1'b0 || tick_missed !== 1'b0 || mem_read !== 1'b0)
      $display("FAIL reset_flags: got valid=%b missed=%b read=%b required 0 0 0",
               audio_valid, tick_missed, mem_read);
    else passes++;
    tick(); wait_acc(1);
    checks++;
    if (acc_log[0] !== 23'h0) $display("FAIL reset_first_fetch: got %h required 000000", acc_log[0]);
    else passes++;
    $display("test_reset done");
  endtask

  task automatic test_forward();
    logic [15:0] exp_s [4];
    exp_s[0] = 16'hAAAA; exp_s[1] = 16'hBBBB; exp_s[2] = 16'hCCCC; exp_s[3] = 16'hDDDD;
    do_reset();
    direction = 1'b1; stall_cfg = 0; rd_lat_cfg = 1;
    for (int i = 0; i < 4; i++) begin
      tick(); wait_valid(i + 1);
      checks++;
      if (last_sample !== exp_s[i])
        $display("FAIL fwd_sample%0d: got %h required %h", i, last_sample, exp_s[i]);
      else passes++;
    end
    tick(); wait_acc(3);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (acc_log[i] !== 23'(i))
        $display("FAIL fwd_addr%0d: got %h required %h", i, acc_log[i], 23'(i));
      else passes++;
    end
    $display("test_forward done");
  endtask

  task automatic test_backward_wrap();
    // From START going backward: step after word 0 wraps to END.
    do_reset();
    direction = 1'b0; stall_cfg = 0; rd_lat_cfg = 1;
    tick(); wait_valid(1);
    checks++;
    if (last_sample !== 16'hBBBB) $display("FAIL bwd_w0_hi: got %h required BBBB", last_sample);
    else passes++;
    tick(); wait_valid(2);
    checks++;
    if (last_sample !== 16'hAAAA) $display("FAIL bwd_w0_lo: got %h required AAAA", last_sample);
    else passes++;
    tick(); wait_valid(3);
    checks++;
    if (acc_log[1] !== 23'h07FFFF) $display("FAIL bwd_wrap_addr: got %h required 07ffff", acc_log[1]);
    else passes++;
    // Restart backward lands on END.
    do_reset();
    direction = 1'b0;
    restart_pulse();
    tick(); wait_valid(1);
    checks++;
    if (acc_log[0] !== 23'h07FFFF) $display("FAIL bwd_restart_addr: got %h required 07ffff", acc_log[0]);
    else passes++;
    checks++;
    if (last_sample !== 16'h2222) $display("FAIL bwd_end_hi: got %h required 2222", last_sample);
    else passes++;
    tick(); wait_valid(2);
    checks++;
    if (last_sample !== 16'h1111) $display("FAIL bwd_end_lo: got %h required 1111", last_sample);
    else passes++;
    tick(); wait_acc(2);
    checks++;
    if (acc_log[1] !== 23'h07FFFE) $display("FAIL bwd_next_addr: got %h required 07fffe", acc_log[1]);
    else passes++;
    $display("test_backward_wrap done");
  endtask

  task automatic test_stall();
    do_reset();
    direction = 1'b1; stall_cfg = 5; rd_lat_cfg = 2;
    tick();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (mem_read !== 1'b1 || mem_address !== 23'h0)
        $display("FAIL stall_hold%0d: got read=%b addr=%h required 1 000000", i, mem_read, mem_address);
      else passes++;
      @(negedge clock);
    end
    wait_valid(1);
    stall_cfg = 0;
    checks++;
    if (av_cyc !== rdv_cyc + 1)
      $display("FAIL stall_latency: got valid cycle %0d required %0d", av_cyc, rdv_cyc + 1);
    else passes++;
    repeat (6) @(negedge clock);
    checks++;
    if (acc_cnt !== 1) $display("FAIL stall_reads: got %0d required 1", acc_cnt);
    else passes++;
    checks++;
    if (valid_cnt !== 1) $display("FAIL stall_valids: got %0d required 1", valid_cnt);
    else passes++;
    $display("test_stall done");
  endtask

  task automatic test_pause();
    do_reset();
    direction = 1'b1; stall_cfg = 0; rd_lat_cfg = 4;
    tick(); wait_acc(1);
    pause = 1'b1;
    sample_tick = 1'b1;
    repeat (10) @(negedge clock);
    sample_tick = 1'b0;
    checks++;
    if (valid_cnt !== 1) $display("FAIL pause_valids: got %0d required 1", valid_cnt);
    else passes++;
    checks++;
    if (last_sample !== 16'hAAAA) $display("FAIL pause_sample: got %h required AAAA", last_sample);
    else passes++;
    checks++;
    if (acc_cnt !== 1) $display("FAIL pause_reads: got %0d required 1", acc_cnt);
    else passes++;
    checks++;
    if (tick_missed !== 1'b0) $display("FAIL pause_missed: got %b required 0", tick_missed);
    else passes++;
    @(negedge clock);
    pause = 1'b0;
    tick(); wait_valid(2);
    checks++;
    if (last_sample !== 16'hBBBB) $display("FAIL pause_resume: got %h required BBBB", last_sample);
    else passes++;
    $display("test_pause done");
  endtask

  task automatic test_restart_inflight();
    do_reset();
    direction = 1'b1; stall_cfg = 0; rd_lat_cfg = 1;
    for (int i = 0; i < 10; i++) begin
      tick(); wait_valid(i + 1);
    end
    rd_lat_cfg = 6;
    tick(); wait_acc(6);
    checks++;
    if (acc_log[5] !== 23'h5) $display("FAIL rst_inflight_addr: got %h required 000005", acc_log[5]);
    else passes++;
    restart_pulse();
    repeat (12) @(negedge clock);
    checks++;
    if (rdv_cnt !== 6) $display("FAIL rst_data_returned: got %0d required 6", rdv_cnt);
    else passes++;
    checks++;
    if (valid_cnt !== 10) $display("FAIL rst_discard: got %0d required 10", valid_cnt);
    else passes++;
    checks++;
    if (tick_missed !== 1'b0) $display("FAIL rst_missed: got %b required 0", tick_missed);
    else passes++;
    rd_lat_cfg = 1;
    tick(); wait_valid(11);
    checks++;
    if (acc_log[6] !== 23'h0) $display("FAIL rst_next_addr: got %h required 000000", acc_log[6]);
    else passes++;
    checks++;
    if (last_sample !== 16'hAAAA) $display("FAIL rst_next_sample: got %h required AAAA", last_sample);
    else passes++;
    $display("test_restart_inflight done");
  endtask

  task automatic test_overrun();
    do_reset();
    direction = 1'b1; stall_cfg = 0; rd_lat_cfg = 4;
    tick(); wait_acc(1);
    tick();
    checks++;
    if (tick_missed !== 1'b1) $display("FAIL ovr_set: got %b required 1", tick_missed);
    else passes++;
    wait_valid(1);
    for (int i = 0; i < 7; i++) begin
      tick(); wait_valid(i + 2);
    end
    checks++;
    if (valid_cnt !== 8) $display("FAIL ovr_valids: got %0d required 8", valid_cnt);
    else passes++;
    checks++;
    if (tick_missed !== 1'b1) $display("FAIL ovr_sticky: got %b required 1", tick_missed);
    else passes++;
    restart_pulse();
    checks++;
    if (tick_missed !== 1'b0) $display("FAIL ovr_clear: got %b required 0", tick_missed);
    else passes++;
    $display("test_overrun done");
  endtask

  initial begin
    direction    = 1'b1;
    mem_readdata = 32'h0;
    test_reset();
    test_forward();
    test_backward_wrap();
    test_stall();
    test_pause();
    test_restart_inflight();
    test_overrun();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
